// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared opcodes, fetch FSM encoding, BHT counter type and immediate decoders
package if_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t BHT_CTR_RESET = 2'b01;

  // Sign-extended J-type immediate.
  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  // Sign-extended B-type immediate.
  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/if_bht.sv
// rtl/if_bht.sv - branch history table of 2-bit saturating counters
//
// Ports:
//   clk_i, rst_i     clock, asynchronous active-low reset (counters -> 2'b01)
//   lookup_pc_i      PC being fetched
//   taken_o          prediction for lookup_pc_i (counter MSB)
//   upd_en_i         a conditional branch was resolved this cycle
//   upd_pc_i         PC of the resolved branch
//   upd_taken_i      resolved outcome
module if_bht
  import if_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lookup_pc_i,
  output logic        taken_o,
  input  logic        upd_en_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i
);

  localparam int NUM_ENTRIES = 1 << IDX_W;

  bht_ctr_t         ctr_q [NUM_ENTRIES];
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic             unused_pc_bits;

  assign lk_idx = lookup_pc_i[IDX_W+1:2];
  assign up_idx = upd_pc_i[IDX_W+1:2];

  // Combinational read of the registered array: a same-entry update in the
  // same cycle is only visible from the next cycle on.
  assign taken_o = ctr_q[lk_idx][1];

  assign unused_pc_bits = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0],
                            upd_pc_i[31:IDX_W+2], upd_pc_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ctr_q[i] <= BHT_CTR_RESET;
      end
    end else if (upd_en_i) begin
      if (upd_taken_i) begin
        if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
      end else begin
        if (ctr_q[up_idx] != 2'b00) ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - RISC-V IF stage: PC, I-cache handshake, next-PC prediction, redirect/flush
//
// Optional feature macro: IF_BHT_EN (conditional branches predicted by a BHT;
// otherwise predicted not-taken and bp_* are ignored). JAL is always taken.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   stall_i                 hazard unit hold of PC and IF/ID
//   redirect_i/_pc_i        EX refetch request and target
//   bp_update_i/_pc_i/_taken_i  branch resolution for the BHT
//   icache_req_o/_addr_o    fetch request and address (= pc_r)
//   icache_rdata_i/_stall_i instruction word and miss indication
//   Instr_o, PC_o, imm_o    IF/ID data inputs
//   IF_ID_Write_o, flush_o  IF/ID write enable and flush
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BHT_IDX_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        bp_update_i,
  input  logic [31:0] bp_pc_i,
  input  logic        bp_taken_i,
  output logic        icache_req_o,
  output logic [31:0] icache_addr_o,
  input  logic [31:0] icache_rdata_i,
  input  logic        icache_stall_i,
  output logic [31:0] Instr_o,
  output logic [31:0] PC_o,
  output logic [31:0] imm_o,
  output logic        IF_ID_Write_o,
  output logic        flush_o
);

  fetch_state_e state_q;
  logic [31:0]  pc_r;
  logic [31:0]  pend_pc_q;
  logic         active_q;   // low for the first cycle after reset release

  logic         fetching;
  logic         is_jal;
  logic         is_branch;
  logic         pred_taken;
  logic [31:0]  imm_sel;
  logic [31:0]  next_pc;
  logic [31:0]  rpc_aligned;

  assign fetching    = active_q && (state_q == FETCH);
  assign is_jal      = (icache_rdata_i[6:0] == OPC_JAL);
  assign is_branch   = (icache_rdata_i[6:0] == OPC_BRANCH);
  assign rpc_aligned = {redirect_pc_i[31:2], 2'b00};

`ifdef IF_BHT_EN
  if_bht #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .lookup_pc_i (pc_r),
    .taken_o     (pred_taken),
    .upd_en_i    (bp_update_i),
    .upd_pc_i    (bp_pc_i),
    .upd_taken_i (bp_taken_i)
  );
`else
  logic unused_bp;
  assign unused_bp  = ^{bp_update_i, bp_pc_i, bp_taken_i, BHT_IDX_W[0]};
  assign pred_taken = 1'b0;
`endif

  always_comb begin
    imm_sel = 32'h0;
    if (is_jal) begin
      imm_sel = imm_j(icache_rdata_i);
    end else if (is_branch) begin
      imm_sel = imm_b(icache_rdata_i);
    end
  end

  // Compressed-style offsets can set bit 1; the PC is kept word aligned.
  assign next_pc = ((is_jal || (is_branch && pred_taken)) ? (pc_r + imm_sel)
                                                          : (pc_r + 32'd4))
                   & ~32'h3;

  assign icache_req_o  = active_q;
  assign icache_addr_o = pc_r;
  assign Instr_o       = fetching ? icache_rdata_i : 32'h0;
  assign PC_o          = fetching ? pc_r : 32'h0;
  assign imm_o         = (fetching && !icache_stall_i) ? imm_sel : 32'h0;
  assign IF_ID_Write_o = fetching && !icache_stall_i && !stall_i && !redirect_i;
  assign flush_o       = active_q && redirect_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= FETCH;
      pc_r      <= {RESET_PC[31:2], 2'b00};
      pend_pc_q <= 32'h0;
      active_q  <= 1'b0;
    end else if (!active_q) begin
      active_q <= 1'b1;
    end else begin
      case (state_q)
        FETCH: begin
          if (redirect_i) begin
            // During a miss the cache needs a stable address, so the target
            // waits in pend_pc until the miss completes.
            if (icache_stall_i) begin
              pend_pc_q <= rpc_aligned;
              state_q   <= DRAIN;
            end else begin
              pc_r <= rpc_aligned;
            end
          end else if (!icache_stall_i && !stall_i) begin
            pc_r <= next_pc;
          end
        end
        DRAIN: begin
          if (!icache_stall_i) begin
            pc_r    <= redirect_i ? rpc_aligned : pend_pc_q;
            state_q <= FETCH;
          end else if (redirect_i) begin
            pend_pc_q <= rpc_aligned;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        bp_update_i = 1'b0;
  logic [31:0] bp_pc_i = 32'h0;
  logic        bp_taken_i = 1'b0;
  logic        icache_req_o;
  logic [31:0] icache_addr_o;
  logic [31:0] icache_rdata_i;
  logic        icache_stall_i = 1'b0;
  logic [31:0] Instr_o;
  logic [31:0] PC_o;
  logic [31:0] imm_o;
  logic        IF_ID_Write_o;
  logic        flush_o;

  int total = 0;
  int bad = 0;

`ifdef IF_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  // Instruction memory plus, per word, what was encoded there.
  logic [31:0] mem      [256];
  int          mem_kind [256];   // 0 other, 1 JAL, 2 branch
  logic [31:0] mem_off  [256];

  assign icache_rdata_i = mem[icache_addr_o[9:2]];

  always #5 clk_i = ~clk_i;

  if_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BHT_IDX_W (4)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .bp_update_i    (bp_update_i),
    .bp_pc_i        (bp_pc_i),
    .bp_taken_i     (bp_taken_i),
    .icache_req_o   (icache_req_o),
    .icache_addr_o  (icache_addr_o),
    .icache_rdata_i (icache_rdata_i),
    .icache_stall_i (icache_stall_i),
    .Instr_o        (Instr_o),
    .PC_o           (PC_o),
    .imm_o          (imm_o),
    .IF_ID_Write_o  (IF_ID_Write_o),
    .flush_o        (flush_o)
  );

  function automatic logic [31:0] enc_jal(input logic [31:0] off);
    enc_jal = {off[20], off[10:1], off[11], off[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_br(input logic [31:0] off);
    enc_br = {off[12], off[10:5], 5'd2, 5'd3, 3'b000, off[4:1], off[11], 7'b1100011};
  endfunction

  task automatic put(input int idx, input int kind, input logic [31:0] off);
    logic [31:0] r;
    r = $urandom;
    mem_kind[idx] = kind;
    mem_off[idx]  = (kind == 0) ? 32'h0 : off;
    if (kind == 1)      mem[idx] = enc_jal(off);
    else if (kind == 2) mem[idx] = enc_br(off);
    else                mem[idx] = {r[31:7], 7'b0010011};
  endtask

  task automatic fill_plain();
    for (int i = 0; i < 256; i++) put(i, 0, 32'h0);
  endtask

  // Apply one cycle of inputs at the falling edge; outputs are settled 1 time unit later.
  task automatic drive(input logic st, input logic ist, input logic rd, input logic [31:0] rpc,
                       input logic bpu, input logic [31:0] bpc, input logic bpt);
    @(negedge clk_i);
    stall_i = st; icache_stall_i = ist; redirect_i = rd; redirect_pc_i = rpc;
    bp_update_i = bpu; bp_pc_i = bpc; bp_taken_i = bpt;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0; stall_i = 0; icache_stall_i = 0; redirect_i = 1'b1; redirect_pc_i = 32'h44;
    bp_update_i = 0; bp_pc_i = 0; bp_taken_i = 0;
    repeat (2) @(negedge clk_i);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk_i);
    rst_i = 1'b1; redirect_i = 1'b0;
  endtask

  task automatic test_reset();
    fill_plain();
    do_reset();
    total++; if (icache_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", icache_req_o); end
    total++; if (IF_ID_Write_o !== 1'b0) begin bad++; $display("FAIL rst_write got=%b want=0", IF_ID_Write_o); end
    total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL rst_flush got=%b want=0", flush_o); end
    total++; if (Instr_o !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", Instr_o); end
    total++; if (PC_o !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", PC_o); end
    total++; if (imm_o !== 32'h0) begin bad++; $display("FAIL rst_imm got=%h want=0", imm_o); end
    total++; if (icache_addr_o !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", icache_addr_o); end
    release_reset();
  endtask

  task automatic test_straight_jal();
    logic [31:0] want [4];
    want[0] = 32'h0; want[1] = 32'h4; want[2] = 32'h8; want[3] = 32'h28;
    put(2, 1, 32'h20);
    for (int i = 0; i < 4; i++) begin
      idle();
      total++; if (icache_addr_o !== want[i]) begin bad++; $display("FAIL seq_addr%0d got=%h want=%h", i, icache_addr_o, want[i]); end
      total++; if (IF_ID_Write_o !== 1'b1) begin bad++; $display("FAIL seq_write%0d got=%b want=1", i, IF_ID_Write_o); end
      total++; if (icache_req_o !== 1'b1) begin bad++; $display("FAIL seq_req%0d got=%b want=1", i, icache_req_o); end
      total++; if (imm_o !== ((i == 2) ? 32'h20 : 32'h0)) begin bad++; $display("FAIL seq_imm%0d got=%h want=%h", i, imm_o, (i == 2) ? 32'h20 : 32'h0); end
      total++; if (PC_o !== want[i]) begin bad++; $display("FAIL seq_pc%0d got=%h want=%h", i, PC_o, want[i]); end
      total++; if (Instr_o !== mem[want[i][9:2]]) begin bad++; $display("FAIL seq_instr%0d got=%h want=%h", i, Instr_o, mem[want[i][9:2]]); end
    end
  endtask

  task automatic test_miss_redirect();
    int flushes;
    put(4, 1, 32'h40);
    drive(0, 0, 1, 32'h10, 0, 0, 0);
    total++; if (flush_o !== 1'b1 || IF_ID_Write_o !== 1'b0) begin bad++; $display("FAIL mr_pos flush=%b write=%b want 1/0", flush_o, IF_ID_Write_o); end
    flushes = 0;
    for (int c = 0; c < 4; c++) begin
      drive(0, (c < 3), (c == 1), 32'h100, 0, 0, 0);
      if (flush_o === 1'b1) flushes++;
      total++; if (icache_addr_o !== 32'h10) begin bad++; $display("FAIL mr_addr%0d got=%h want=10", c, icache_addr_o); end
      total++; if (IF_ID_Write_o !== 1'b0) begin bad++; $display("FAIL mr_write%0d got=%b want=0", c, IF_ID_Write_o); end
      if (c == 0) begin
        total++; if (imm_o !== 32'h0) begin bad++; $display("FAIL mr_imm_forced got=%h want=0", imm_o); end
      end
    end
    total++; if (flushes != 1) begin bad++; $display("FAIL mr_flush_count got=%0d want=1", flushes); end
    idle();
    total++; if (icache_addr_o !== 32'h100) begin bad++; $display("FAIL mr_target got=%h want=100", icache_addr_o); end
    total++; if (IF_ID_Write_o !== 1'b1) begin bad++; $display("FAIL mr_resume got=%b want=1", IF_ID_Write_o); end
  endtask

  task automatic test_stall_redirect();
    for (int c = 0; c < 2; c++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      total++; if (icache_addr_o !== 32'h104 || IF_ID_Write_o !== 1'b0) begin bad++; $display("FAIL st_hold%0d addr=%h write=%b want 104/0", c, icache_addr_o, IF_ID_Write_o); end
    end
    drive(1, 0, 1, 32'h43, 0, 0, 0);
    total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL sr_flush got=%b want=1", flush_o); end
    total++; if (IF_ID_Write_o !== 1'b0) begin bad++; $display("FAIL sr_write got=%b want=0", IF_ID_Write_o); end
    idle();
    total++; if (icache_addr_o !== 32'h40) begin bad++; $display("FAIL sr_addr got=%h want=40", icache_addr_o); end
    total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL sr_flush_end got=%b want=0", flush_o); end
  endtask

  task automatic test_branch_prediction();
    logic [31:0] want;
    want = BHT_ON ? 32'h18 : 32'h24;
    put(8, 2, 32'hFFFF_FFF8);
    drive(0, 0, 1, 32'h20, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 32'h20, 1);
    total++; if (imm_o !== 32'hFFFF_FFF8) begin bad++; $display("FAIL br_imm got=%h want=fffffff8", imm_o); end
    drive(1, 0, 0, 0, 1, 32'h20, 1);
    idle();
    total++; if (IF_ID_Write_o !== 1'b1 || icache_addr_o !== 32'h20) begin bad++; $display("FAIL br_fetch addr=%h write=%b want 20/1", icache_addr_o, IF_ID_Write_o); end
    idle();
    total++; if (icache_addr_o !== want) begin bad++; $display("FAIL br_after2taken got=%h want=%h", icache_addr_o, want); end
    drive(0, 0, 1, 32'h20, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 32'h20, 0);
    idle();
    idle();
    total++; if (icache_addr_o !== want) begin bad++; $display("FAIL br_after_nt got=%h want=%h", icache_addr_o, want); end
  endtask

  // Randomized run against a transaction-level model of the fetch rules.
  task automatic test_random();
    logic [31:0] pc, pend, rpc, bpc, r, nxt;
    logic        draining, st, ist, rd, bpu, bpt, pred, exp_wr;
    int          ctr [16];
    int          idx, k;
    logic [31:0] exp_imm;

    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      k = $urandom_range(0, 9);
      if (k < 2)      put(i, 1, {{11{r[20]}}, r[20:1], 1'b0});
      else if (k < 5) put(i, 2, {{19{r[12]}}, r[12:1], 1'b0});
      else            put(i, 0, 32'h0);
    end
    do_reset();
    release_reset();
    pc = 32'h0; pend = 32'h0; draining = 1'b0;
    for (int i = 0; i < 16; i++) ctr[i] = 1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      st  = ($urandom_range(0, 99) < 20);
      ist = ($urandom_range(0, 99) < 25);
      rd  = ($urandom_range(0, 99) < 8);
      rpc = $urandom;
      bpu = ($urandom_range(0, 99) < 30);
      bpc = $urandom;
      bpt = $urandom_range(0, 1);
      drive(st, ist, rd, rpc, bpu, bpc, bpt);

      idx = int'(pc[9:2]);
      total++; if (icache_req_o !== 1'b1) begin bad++; $display("FAIL rnd_req c%0d got=%b want=1", cyc, icache_req_o); end
      total++; if (icache_addr_o !== pc) begin bad++; $display("FAIL rnd_addr c%0d got=%h want=%h", cyc, icache_addr_o, pc); end
      total++; if (flush_o !== rd) begin bad++; $display("FAIL rnd_flush c%0d got=%b want=%b", cyc, flush_o, rd); end

      if (draining) begin
        total++; if (IF_ID_Write_o !== 1'b0) begin bad++; $display("FAIL rnd_drain_write c%0d got=%b want=0", cyc, IF_ID_Write_o); end
        if (rd) pend = rpc & ~32'h3;
        if (!ist) begin
          pc = pend;
          draining = 1'b0;
        end
      end else begin
        exp_wr  = !ist && !st && !rd;
        exp_imm = ist ? 32'h0 : mem_off[idx];
        total++; if (IF_ID_Write_o !== exp_wr) begin bad++; $display("FAIL rnd_write c%0d got=%b want=%b", cyc, IF_ID_Write_o, exp_wr); end
        total++; if (imm_o !== exp_imm) begin bad++; $display("FAIL rnd_imm c%0d got=%h want=%h", cyc, imm_o, exp_imm); end
        total++; if (PC_o !== pc) begin bad++; $display("FAIL rnd_pc c%0d got=%h want=%h", cyc, PC_o, pc); end
        total++; if (Instr_o !== mem[idx]) begin bad++; $display("FAIL rnd_instr c%0d got=%h want=%h", cyc, Instr_o, mem[idx]); end
        pred = BHT_ON && (ctr[pc[5:2]] >= 2);
        if (rd && !ist) begin
          pc = rpc & ~32'h3;
        end else if (rd) begin
          pend = rpc & ~32'h3;
          draining = 1'b1;
        end else if (exp_wr) begin
          if (mem_kind[idx] == 1 || (mem_kind[idx] == 2 && pred)) nxt = pc + mem_off[idx];
          else nxt = pc + 32'd4;
          pc = nxt & ~32'h3;
        end
      end

      if (BHT_ON && bpu) begin
        if (bpt) ctr[bpc[5:2]] = (ctr[bpc[5:2]] == 3) ? 3 : ctr[bpc[5:2]] + 1;
        else     ctr[bpc[5:2]] = (ctr[bpc[5:2]] == 0) ? 0 : ctr[bpc[5:2]] - 1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_straight_jal();
    test_miss_redirect();
    test_stall_redirect();
    test_branch_prediction();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipelined RISC-V core; sits directly upstream of the IF/ID pipeline register and drives all of its inputs.
- Owns the PC, the I-cache request handshake and next-PC prediction (JAL always taken; conditional branches via BHT).
- Accepts redirects from EX and generates the IF/ID flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BHT_IDX_W, 4, log2 of BHT entries; used only when the BHT is compiled in.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- stall_i  in  1  hazard unit: hold PC and IF/ID contents
- redirect_i  in  1  EX: mispredict or JALR resolved; refetch from redirect_pc_i
- redirect_pc_i  in  32  correct next PC
- bp_update_i  in  1  EX resolved a conditional branch this cycle
- bp_pc_i  in  32  PC of the resolved branch
- bp_taken_i  in  1  actual branch outcome
- icache_req_o  out  1  fetch request
- icache_addr_o  out  32  fetch address (= pc_r)
- icache_rdata_i  in  32  instruction word
- icache_stall_i  in  1  miss in progress; data not valid
- Instr_o  out  32  to IF/ID Instr_i
- PC_o  out  32  to IF/ID PC_i
- imm_o  out  32  to IF/ID imm_i; sign-extended B/J immediate of the fetched instruction, else 0
- IF_ID_Write_o  out  1  to IF/ID IF_ID_Write_i
- flush_o  out  1  to IF/ID flush_i

Behaviour:
- Reset (rst_i, asynchronous, active-low; clock clk_i):
  - pc_r=RESET_PC, state=FETCH.
  - icache_req_o=0, IF_ID_Write_o=0, flush_o=0.
  - Instr_o, PC_o and imm_o read 0.
  - All BHT counters=2'b01.
  - First request is issued on the first cycle after reset release.
- States are FETCH and DRAIN.
- FETCH:
  - icache_req_o=1, icache_addr_o=pc_r.
  - Instr_o=icache_rdata_i, PC_o=pc_r.
  - IF_ID_Write_o=!icache_stall_i && !stall_i.
- Next PC when IF_ID_Write_o=1:
  - opcode 1101111 (JAL): pc_r+immJ.
  - opcode 1100011 with predicted taken: pc_r+immB.
  - otherwise: pc_r+4.
  - Additions are 32-bit and wrap modulo 2^32.
- imm_o:
  - immJ for JAL, immB for branches, 0 otherwise.
  - Forced to 0 while icache_stall_i=1.
- Redirect priority: redirect_i > stall_i > prediction.
- redirect_i=1 in FETCH with icache_stall_i=0:
  - flush_o=1 for exactly that cycle.
  - IF_ID_Write_o=0.
  - pc_r<=redirect_pc_i, regardless of stall_i.
- redirect_i=1 while icache_stall_i=1:
  - Latch pend_pc<=redirect_pc_i and assert flush_o=1 for that cycle.
  - Go to DRAIN.
  - icache_addr_o stays at the old pc_r, because the cache requires a stable address during a miss.
- DRAIN:
  - IF_ID_Write_o=0.
  - A new redirect_i overwrites pend_pc.
  - When icache_stall_i=0, returned data is discarded, pc_r<=pend_pc, and the state returns to FETCH.
- stall_i=1 with no redirect: pc_r holds and IF_ID_Write_o=0; the request is re-issued to the same address.
- pc_r[1:0] are always 0; redirect_pc_i[1:0] is ignored.

Optional Feature:
- Macro: IF_BHT_EN.
- When defined:
  - 2^BHT_IDX_W two-bit saturating counters, indexed by pc[BHT_IDX_W+1:2].
  - Predict taken when counter[1]=1.
  - bp_update_i increments the counter on taken, decrements on not-taken, saturating at 3/0.
  - A same-entry update and lookup in the same cycle returns the pre-update value.
- When undefined:
  - Conditional branches are always predicted not-taken; bp_* inputs are ignored.
  - JAL is still predicted taken.

Decomposition:
- if_pkg:
  - Opcode constants OPC_JAL=7'b1101111 and OPC_BRANCH=7'b1100011.
  - State encoding FETCH/DRAIN.
  - 2-bit counter typedef and its reset value 2'b01.
- Sub-module if_bht, instantiated only under IF_BHT_EN:
  - Lookup port: pc -> taken.
  - Update port: bp_update_i, bp_pc_i, bp_taken_i.

Test Plan:
- Reset release with straight-line code, no stalls:
  - addr sequence 0x0, 0x4, 0x8.
  - IF_ID_Write_o=1 every cycle.
  - imm_o=0 for non-branch instructions.
- JAL at 0x8 with immJ=+0x20:
  - next fetch 0x28.
  - imm_o=0x20 during the JAL cycle.
- icache_stall_i high for 3 cycles at 0x10, then redirect_i=1 with 0x100 in the second miss cycle:
  - flush_o pulses once.
  - addr stays at 0x10 through the miss.
  - After the stall drops, no write occurs, then addr=0x100.
- stall_i and redirect_i (0x40) asserted together:
  - flush_o=1, IF_ID_Write_o=0.
  - next addr 0x40.
- IF_BHT_EN, branch at 0x20 with immB=-8:
  - Two bp_update_i taken pulses move the counter from 01 to 11.
  - The next fetch of 0x20 predicts 0x18.
  - One not-taken update leaves it still predicting taken (10).
- IF_BHT_EN undefined, same branch:
  - Always fetches 0x24 after 0x20, regardless of updates.
